// File: rtl/gps_cfg_pkg.sv
// gps_cfg_pkg: shared state encoding, control-bit layout and frame constants
// for the GPS generator configuration controller.
package gps_cfg_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_CHECK, ST_PEND} state_t;

    localparam int CTL_RUN        = 0;
    localparam int CTL_NOISE_OFF  = 1;
    localparam int CTL_SIGNAL_OFF = 2;
    localparam int CTL_MSG_PRESET = 3;
    localparam int CTL_IMMEDIATE  = 4;

    localparam int FRAME_LEN   = 8;
    localparam int PAYLOAD_LEN = FRAME_LEN - 2;

    localparam logic [7:0] HDR_BYTE_DEF    = 8'hA5;
    localparam int         TIMEOUT_CYC_DEF = 1024;

    // Checksum covers the header and every payload byte.
    function automatic logic [7:0] frame_xor(input logic [7:0] hdr,
                                             input logic [PAYLOAD_LEN-1:0][7:0] p);
        frame_xor = hdr;
        for (int i = 0; i < PAYLOAD_LEN; i++) frame_xor ^= p[i];
    endfunction

endpackage

// File: rtl/gps_cfg_framer.sv
// gps_cfg_framer: header hunt, payload capture into a shadow, checksum check,
// inter-byte timeout, and the PEND hold until the top applies the config.
module gps_cfg_framer
    import gps_cfg_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        valid,
    input  logic [7:0]                  data,
    input  logic                        commit,
    output logic                        ready,
    output state_t                      state,
    output logic [PAYLOAD_LEN-1:0][7:0] shadow,
    output logic                        err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    cnt;
    logic [CW-1:0] idle_cnt;
    logic          acc;

    assign ready = state != ST_PEND;
    assign acc   = valid && ready;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            idle_cnt <= '0;
            shadow   <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (acc && data == HDR_BYTE) begin
                        state <= ST_PAYLOAD;
                        cnt   <= '0;
                    end
                end
                ST_PAYLOAD, ST_CHECK: begin
                    if (acc) begin
                        idle_cnt <= '0;
                        if (state == ST_PAYLOAD) begin
                            shadow[cnt] <= data;
                            cnt         <= cnt + 3'd1;
                            if (cnt == 3'(PAYLOAD_LEN - 1)) state <= ST_CHECK;
                        end else if (data == frame_xor(HDR_BYTE, shadow) && shadow[0][7:5] == 3'b000) begin
                            state <= ST_PEND;
                        end else begin
                            err    <= 1'b1;
                            state  <= ST_IDLE;
                            shadow <= '0;
                        end
                    end else if (idle_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        err      <= 1'b1;
                        state    <= ST_IDLE;
                        shadow   <= '0;
                        idle_cnt <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                ST_PEND: if (commit) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gps_cfg_ctrl.sv
// gps_cfg_ctrl: applies checked configuration frames to the generator outputs,
// either immediately or aligned to the next code epoch.
module gps_cfg_ctrl
    import gps_cfg_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cfg_valid_in,
    input  logic [7:0]  cfg_data_in,
    output logic        cfg_ready_out,
    input  logic        epoch_in,
    output logic        ena_out,
    output logic [4:0]  n_sat_out,
    output logic [15:0] ca_phase_out,
    output logic [7:0]  doppler_out,
    output logic [7:0]  snr_out,
    output logic        noise_off_out,
    output logic        signal_off_out,
    output logic        use_msg_preset_out,
    output logic        commit_out,
    output logic        err_out,
    output logic        busy_out
);

    state_t                      state;
    logic [PAYLOAD_LEN-1:0][7:0] shadow;
    logic                        commit;

    gps_cfg_framer #(.HDR_BYTE(HDR_BYTE), .TIMEOUT_CYC(TIMEOUT_CYC)) u_framer (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .valid  (cfg_valid_in),
        .data   (cfg_data_in),
        .commit (commit),
        .ready  (cfg_ready_out),
        .state  (state),
        .shadow (shadow),
        .err    (err_out)
    );

    // A stopped generator has no epoch to align to, so apply at once.
    assign commit   = state == ST_PEND && (shadow[5][CTL_IMMEDIATE] || !ena_out || epoch_in);
    assign busy_out = state != ST_IDLE;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ena_out            <= 1'b0;
            n_sat_out          <= '0;
            ca_phase_out       <= '0;
            doppler_out        <= '0;
            snr_out            <= '0;
            noise_off_out      <= 1'b0;
            signal_off_out     <= 1'b0;
            use_msg_preset_out <= 1'b0;
            commit_out         <= 1'b0;
        end else begin
            commit_out <= commit;
            if (commit) begin
                ena_out            <= shadow[5][CTL_RUN];
                n_sat_out          <= shadow[0][4:0];
                ca_phase_out       <= {shadow[1], shadow[2]};
                doppler_out        <= shadow[3];
                snr_out            <= shadow[4];
                noise_off_out      <= shadow[5][CTL_NOISE_OFF];
                signal_off_out     <= shadow[5][CTL_SIGNAL_OFF];
                use_msg_preset_out <= shadow[5][CTL_MSG_PRESET];
            end
        end
    end

endmodule

// File: tb/tb_gps_cfg_ctrl.sv
// tb_gps_cfg_ctrl: directed frames; expected commit/err pulses are queued by
// the stimulus and popped by an independent monitor on the falling edge.
module tb_gps_cfg_ctrl;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [40:0] cfg;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cfg_valid_in;
    logic [7:0]  cfg_data_in;
    logic        cfg_ready_out;
    logic        epoch_in;
    logic        ena_out;
    logic [4:0]  n_sat_out;
    logic [15:0] ca_phase_out;
    logic [7:0]  doppler_out;
    logic [7:0]  snr_out;
    logic        noise_off_out;
    logic        signal_off_out;
    logic        use_msg_preset_out;
    logic        commit_out;
    logic        err_out;
    logic        busy_out;

    exp_t        sb[$];
    logic [40:0] cur = '0;
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;

    gps_cfg_ctrl dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .cfg_valid_in       (cfg_valid_in),
        .cfg_data_in        (cfg_data_in),
        .cfg_ready_out      (cfg_ready_out),
        .epoch_in           (epoch_in),
        .ena_out            (ena_out),
        .n_sat_out          (n_sat_out),
        .ca_phase_out       (ca_phase_out),
        .doppler_out        (doppler_out),
        .snr_out            (snr_out),
        .noise_off_out      (noise_off_out),
        .signal_off_out     (signal_off_out),
        .use_msg_preset_out (use_msg_preset_out),
        .commit_out         (commit_out),
        .err_out            (err_out),
        .busy_out           (busy_out)
    );

    always #5 clk_in = ~clk_in;
    always @(negedge clk_in) cyc <= cyc + 1;

    function automatic logic [40:0] outs();
        return {ena_out, n_sat_out, ca_phase_out, doppler_out, snr_out,
                noise_off_out, signal_off_out, use_msg_preset_out};
    endfunction

    function automatic logic [40:0] mk(logic ena, logic [4:0] ns, logic [15:0] ca, logic [7:0] dop,
                                       logic [7:0] snr, logic no, logic so, logic pre);
        return {ena, ns, ca, dop, snr, no, so, pre};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    endtask

    task automatic push_commit(input int c, input logic [40:0] cfg);
        sb.push_back('{is_err: 1'b0, cyc: c, cfg: cfg});
        cur = cfg;
    endtask

    task automatic push_err(input int c);
        sb.push_back('{is_err: 1'b1, cyc: c, cfg: cur});
    endtask

    // Bytes taken MSB first; returns with cyc equal to the last accept edge.
    task automatic send(input logic [63:0] f, input int n);
        cfg_valid_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            cfg_data_in = f[63-8*i -: 8];
            @(posedge clk_in);
            #1;
        end
        cfg_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic epoch_pulse();
        epoch_in = 1'b1;
        @(posedge clk_in);
        #1;
        epoch_in = 1'b0;
    endtask

    always @(negedge clk_in) begin
        if (commit_out || err_out) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_pulse: commit=%0b err=%0b with empty queue (cyc %0d)",
                         commit_out, err_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", 64'({commit_out, err_out}), e.is_err ? 64'd1 : 64'd2);
                check("pulse_cyc", 64'(cyc), 64'(e.cyc));
                check("pulse_cfg", 64'(outs()), 64'(e.cfg));
            end
        end
    end

    initial begin
        rst_in       = 1'b1;
        cfg_valid_in = 1'b0;
        cfg_data_in  = '0;
        epoch_in     = 1'b0;
        idle(3);
        check("reset_outs", 64'(outs()), 64'd0);
        check("reset_flags", 64'({commit_out, err_out, busy_out, cfg_ready_out}), 64'b0001);
        rst_in = 1'b0;
        idle(2);

        // Immediate commit from a stopped generator, one clock after checksum.
        send(64'hA5_03_12_34_40_02_11_D3, 8);
        push_commit(cyc + 1, mk(1'b1, 5'd3, 16'h1234, 8'h40, 8'h02, 1'b0, 1'b0, 1'b0));
        idle(3);
        check("idle_after_commit", 64'({busy_out, cfg_ready_out}), 64'b01);

        // Epoch outside PEND does nothing.
        epoch_pulse();
        idle(2);

        // Running generator, non-immediate: held in PEND until epoch 37 cycles later.
        send(64'hA5_07_AB_CD_F0_05_01_30, 8);
        for (int i = 0; i < 36; i++) begin
            idle(1);
            check("pend_hold", 64'({cfg_ready_out, busy_out, outs()}), 64'({1'b0, 1'b1, cur}));
        end
        push_commit(cyc + 1, mk(1'b1, 5'd7, 16'hABCD, 8'hF0, 8'h05, 1'b0, 1'b0, 1'b0));
        epoch_pulse();
        idle(2);

        // Corrupted checksum, then the good version of the same frame.
        send(64'hA5_01_00_10_20_03_0E_98, 8);
        push_err(cyc);
        idle(3);
        check("bad_csum_hold", 64'({busy_out, outs()}), 64'({1'b0, cur}));
        send(64'hA5_01_00_10_20_03_0E_99, 8);
        idle(2);
        push_commit(cyc + 1, mk(1'b0, 5'd1, 16'h0010, 8'h20, 8'h03, 1'b1, 1'b1, 1'b1));
        epoch_pulse();
        idle(2);

        // Stray bytes in IDLE, then a truncated frame that times out.
        send(64'h00_00_5A_00_00_00_00_00, 3);
        idle(2);
        check("stray_idle", 64'(busy_out), 64'd0);
        send(64'hA5_01_02_03_00_00_00_00, 4);
        push_err(cyc + 1024);
        idle(1023);
        check("timeout_not_yet", 64'(busy_out), 64'd1);
        idle(4);
        check("timeout_busy", 64'({busy_out, cfg_ready_out}), 64'b01);

        // Upper bits set in B0 with a consistent checksum.
        send(64'hA5_23_00_00_00_00_11_97, 8);
        push_err(cyc);
        idle(3);
        check("b0_hold", 64'(outs()), 64'(cur));

        // Stopped generator commits at once even without the immediate bit.
        send(64'hA5_1F_FF_FF_7F_80_00_45, 8);
        push_commit(cyc + 1, mk(1'b0, 5'h1F, 16'hFFFF, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b0));
        idle(3);

        // Start running, park a frame in PEND, then reset.
        send(64'hA5_03_12_34_40_02_11_D3, 8);
        push_commit(cyc + 1, mk(1'b1, 5'd3, 16'h1234, 8'h40, 8'h02, 1'b0, 1'b0, 1'b0));
        idle(3);
        send(64'hA5_07_AB_CD_F0_05_01_30, 8);
        idle(5);
        check("pre_reset_pend", 64'({cfg_ready_out, busy_out}), 64'b01);
        rst_in = 1'b1;
        #2;
        check("async_reset_outs", 64'(outs()), 64'd0);
        check("async_reset_flags", 64'({commit_out, err_out, busy_out, cfg_ready_out}), 64'b0001);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        cur = '0;
        epoch_pulse();
        idle(5);
        check("post_reset_outs", 64'(outs()), 64'd0);

        check("queue_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
